arbitro_jogadas: RTL

ARBITRO_JOGADAS -- requirements
Module: arbitro_jogadas

---
 rtl/arbitro_jogadas_pkg.sv | 28 ++
 rtl/arbitro_jogadas_contador_pontos_sat.sv | 32 +++
 rtl/arbitro_jogadas.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arbitro_jogadas_pkg.sv
// Shared state codes and winner encodings for the unidade_controle family of match arbiters.
package arbitro_jogadas_pkg;

  localparam int unsigned W_ESTADO   = 4;
  localparam int unsigned W_VENCEDOR = 2;

  typedef enum logic [W_ESTADO-1:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    ESPERA     = 4'd2,
    REGISTRA   = 4'd3,
    COMPARA    = 4'd4,
    PROXIMA    = 4'd5,
    RODADA_OK  = 4'd6,
    FALHA      = 4'd7,
    TROCA      = 4'd8,
    FIM_RODADA = 4'd9,
    FIM        = 4'd10
  } estado_t;

  typedef enum logic [W_VENCEDOR-1:0] {
    VENC_NENHUM = 2'b00,
    VENC_J1     = 2'b01,
    VENC_J2     = 2'b10,
    VENC_EMPATE = 2'b11
  } vencedor_t;

endpackage

// File: rtl/arbitro_jogadas_contador_pontos_sat.sv
// Saturating round-win counter: synchronous clear has priority over count enable.
module contador_pontos_sat #(
  parameter int unsigned W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor
);

  localparam logic [W-1:0] VALOR_MAX = '1;

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta && (valor_q != VALOR_MAX)) begin
      valor_d = valor_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valor_q <= '0;
    else        valor_q <= valor_d;
  end

  assign valor = valor_q;

endmodule

// File: rtl/arbitro_jogadas.sv
// Two-player turn arbiter: sequences rounds over a shared datapath, tracks scores and the match winner.
module arbitro_jogadas
  import arbitro_jogadas_pkg::*;
#(
  parameter int unsigned W_PONTOS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  jogada_j1,
  input  logic                  jogada_j2,
  input  logic                  igual,
  input  logic                  enderecoIgualSequencia,
  input  logic                  fimS,
  input  logic                  timeout,
  output logic                  zeraE,
  output logic                  contaE,
  output logic                  zeraS,
  output logic                  contaS,
  output logic                  zeraR,
  output logic                  registraR,
  output logic                  zeraTMR,
  output logic                  contaTMR,
  output logic                  vez,
  output logic [W_PONTOS-1:0]   pontos_j1,
  output logic [W_PONTOS-1:0]   pontos_j2,
  output logic [W_VENCEDOR-1:0] vencedor,
  output logic                  pronto,
  output logic [W_ESTADO-1:0]   db_estado
);

  estado_t   estado_q, estado_d;
  logic      vez_q, vez_d;
  vencedor_t vencedor_q, vencedor_d;
  logic      jogada_atual;

  // Only the player whose turn it is can advance the FSM.
  assign jogada_atual = vez_q ? jogada_j2 : jogada_j1;

  always_comb begin
    estado_d  = estado_q;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraS     = 1'b0;
    contaS    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    zeraTMR   = 1'b0;
    contaTMR  = 1'b0;
    pronto    = 1'b0;
    case (estado_q)
      INICIAL: begin
        zeraR = 1'b1;
        zeraS = 1'b1;
        zeraE = 1'b1;
        if (iniciar) estado_d = PREPARA;
      end
      PREPARA: begin
        zeraE    = 1'b1;
        zeraR    = 1'b1;
        zeraTMR  = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
        contaTMR = 1'b1;
        if (jogada_atual)  estado_d = REGISTRA;
        else if (timeout)  estado_d = FALHA;
      end
      REGISTRA: begin
        registraR = 1'b1;
        estado_d  = COMPARA;
      end
      COMPARA: begin
        if (!igual)                      estado_d = FALHA;
        else if (enderecoIgualSequencia) estado_d = RODADA_OK;
        else                             estado_d = PROXIMA;
      end
      PROXIMA: begin
        contaE   = 1'b1;
        zeraTMR  = 1'b1;
        estado_d = ESPERA;
      end
      RODADA_OK: estado_d = TROCA;
      FALHA:     estado_d = TROCA;
      // J1 always opens a round, so J2 finishing closes it.
      TROCA:     estado_d = vez_q ? FIM_RODADA : PREPARA;
      FIM_RODADA: begin
        if (fimS) begin
          estado_d = FIM;
        end else begin
          contaS   = 1'b1;
          estado_d = PREPARA;
        end
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) estado_d = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_comb begin
    vez_d = vez_q;
    if (estado_q == INICIAL)    vez_d = 1'b0;
    else if (estado_q == TROCA) vez_d = ~vez_q;
  end

  // Scores are stable from FIM_RODADA onwards, so the comparison on entry to FIM holds while there.
  always_comb begin
    vencedor_d = VENC_NENHUM;
    if (estado_d == FIM) begin
      if (pontos_j1 > pontos_j2)      vencedor_d = VENC_J1;
      else if (pontos_j2 > pontos_j1) vencedor_d = VENC_J2;
      else                            vencedor_d = VENC_EMPATE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= INICIAL;
      vez_q      <= 1'b0;
      vencedor_q <= VENC_NENHUM;
    end else begin
      estado_q   <= estado_d;
      vez_q      <= vez_d;
      vencedor_q <= vencedor_d;
    end
  end

  contador_pontos_sat #(.W(W_PONTOS)) u_pontos_j1 (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q == INICIAL),
    .conta ((estado_q == RODADA_OK) && !vez_q),
    .valor (pontos_j1)
  );

  contador_pontos_sat #(.W(W_PONTOS)) u_pontos_j2 (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q == INICIAL),
    .conta ((estado_q == RODADA_OK) && vez_q),
    .valor (pontos_j2)
  );

  assign vez       = vez_q;
  assign vencedor  = vencedor_q;
  assign db_estado = estado_q;

endmodule
